// File: rtl/lsu_mmio_pkg.sv
// Shared types, address-map constants and lane helpers for the MMIO load-store unit.
//   size_e   : request access size (byte / half / word; 2'b11 is reserved)
//   state_e  : request FSM states
//   byte_en / store_lanes / load_extract / is_misaligned : lane steering helpers
package lsu_mmio_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_e;

    localparam logic [19:0] OUT_BASE = 20'h10000;
    localparam logic [19:0] IN_BASE  = 20'h10010;

    localparam int ERR_MISALIGN = 0;
    localparam int ERR_UNMAPPED = 1;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return lane[0];
            SZ_W:    return |lane;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_B:    return 4'b0001 << lane;
            SZ_H:    return 4'b0011 << {lane[1], 1'b0};
            SZ_W:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Replicate the right-justified store data across every lane so the byte
    // enables alone pick where it lands.
    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            SZ_B:    return {4{wdata[7:0]}};
            SZ_H:    return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [1:0]  size,
                                                 input logic [1:0]  lane,
                                                 input logic        uns,
                                                 input logic [31:0] word);
        logic [31:0] sh;
        sh = word >> {lane, 3'b000};
        case (size)
            SZ_B:    return uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            SZ_H: begin
                sh = word >> {lane[1], 4'b0000};
                return uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            end
            default: return word;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mmio_ram.sv
// Byte-enabled synchronous data RAM, MEM_DEPTH_W x 32, not reset.
//   i_clk   : clock
//   i_we    : per-byte write enables
//   i_re    : read enable; o_rdata updates one cycle later and holds otherwise
//   i_addr  : word address
//   i_wdata : write data (lanes already steered)
//   o_rdata : registered read data
module lsu_mmio_ram #(
    parameter int MEM_DEPTH_W = 4096,
    parameter int ADDR_W      = $clog2(MEM_DEPTH_W)
) (
    input  logic              i_clk,
    input  logic [3:0]        i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata
);

    logic [31:0] mem [MEM_DEPTH_W];

    always_ff @(posedge i_clk) begin
        for (int b = 0; b < 4; b++) begin
            if (i_we[b]) mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
        if (i_re) o_rdata <= mem[i_addr];
    end

endmodule

// File: rtl/lsu_mmio_pipe.sv
// Handshaked load-store unit serving one request at a time to a data RAM,
// N_OUT memory-mapped output registers and N_IN synchronised input ports.
//   i_clk, i_reset            : clock, synchronous active-high reset
//   i_req_* / o_req_ready     : request channel (we, addr, size, unsigned, wdata)
//   o_rsp_* / i_rsp_ready     : response channel (rdata, err[0]=misalign, err[1]=unmapped)
//   o_out_regs                : flattened output registers, reg k at [32k+31:32k]
//   i_in_ports                : asynchronous board inputs, flattened the same way
//
// state  | meaning
// IDLE   | ready for a request; faults are detected here on acceptance
// ACCESS | RAM read/write or register read/write issued
// RESP   | response held on the response channel until consumed
module lsu_mmio_pipe
    import lsu_mmio_pkg::*;
#(
    parameter int MEM_DEPTH_W = 4096,
    parameter int N_OUT       = 5,
    parameter int N_IN        = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_req_valid,
    output logic                o_req_ready,
    input  logic                i_req_we,
    input  logic [31:0]         i_req_addr,
    input  logic [1:0]          i_req_size,
    input  logic                i_req_unsigned,
    input  logic [31:0]         i_req_wdata,
    output logic                o_rsp_valid,
    input  logic                i_rsp_ready,
    output logic [31:0]         o_rsp_rdata,
    output logic [1:0]          o_rsp_err,
    output logic [32*N_OUT-1:0] o_out_regs,
    input  logic [32*N_IN-1:0]  i_in_ports
);

    localparam int          ADDR_W    = $clog2(MEM_DEPTH_W);
    localparam int          IDX_W     = (N_OUT > N_IN) ? $clog2(N_OUT + 1) : $clog2(N_IN + 1);
    localparam logic [31:0] RAM_BYTES = 32'(4 * MEM_DEPTH_W);

    state_e state_q, state_d;

    logic              accept;
    logic              req_ram, req_out, req_in;
    logic [19:0]       out_off, in_off;
    logic [1:0]        req_err;

    logic              r_we, r_uns, r_ram, r_out;
    logic [31:0]       r_addr, r_wdata, r_word;
    logic [1:0]        r_size, r_err;
    logic [IDX_W-1:0]  r_idx;

    logic [3:0]        be;
    logic [31:0]       wlanes, reg_rd, ram_q;
    logic [3:0]        ram_we;
    logic              ram_re, out_wr;

    logic [31:0]       out_q  [N_OUT];
    logic [32*N_IN-1:0] sync_q [SYNC_STAGES];

    // Request decode; a store to an input port counts as unmapped.
    always_comb begin
        out_off = i_req_addr[31:12] - OUT_BASE;
        in_off  = i_req_addr[31:12] - IN_BASE;
        req_ram = i_req_addr < RAM_BYTES;
        req_out = !req_ram && (32'(out_off) < 32'(N_OUT));
        req_in  = !req_ram && !req_out && (32'(in_off) < 32'(N_IN));
        req_err = '0;
        req_err[ERR_MISALIGN] = is_misaligned(i_req_size, i_req_addr[1:0]);
        req_err[ERR_UNMAPPED] = !(req_ram || req_out || (req_in && !i_req_we));
    end

    assign accept = (state_q == IDLE) && i_req_valid;
    assign be     = byte_en(r_size, r_addr[1:0]);
    assign wlanes = store_lanes(r_size, r_wdata);

    always_ff @(posedge i_clk) begin
        if (i_reset) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = (|req_err) ? RESP : ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    if (i_rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_req_ready = 1'b0;
        o_rsp_valid = 1'b0;
        o_rsp_rdata = '0;
        o_rsp_err   = '0;
        ram_we      = '0;
        ram_re      = 1'b0;
        out_wr      = 1'b0;
        case (state_q)
            IDLE:   o_req_ready = 1'b1;
            ACCESS: begin
                if (r_we) begin
                    // Reset in the access cycle must drop the RAM write too.
                    if (r_ram && !i_reset) ram_we = be;
                    out_wr = r_out;
                end else begin
                    ram_re = r_ram;
                end
            end
            RESP: begin
                o_rsp_valid = 1'b1;
                o_rsp_err   = r_err;
                if (r_err == 2'b00 && !r_we)
                    o_rsp_rdata = load_extract(r_size, r_addr[1:0], r_uns, r_ram ? ram_q : r_word);
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_we    <= 1'b0;
            r_uns   <= 1'b0;
            r_ram   <= 1'b0;
            r_out   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_size  <= '0;
            r_err   <= '0;
            r_idx   <= '0;
            r_word  <= '0;
        end else begin
            if (accept) begin
                r_we    <= i_req_we;
                r_uns   <= i_req_unsigned;
                r_ram   <= req_ram;
                r_out   <= req_out;
                r_addr  <= i_req_addr;
                r_wdata <= i_req_wdata;
                r_size  <= i_req_size;
                r_err   <= req_err;
                r_idx   <= req_out ? out_off[IDX_W-1:0] : in_off[IDX_W-1:0];
            end
            if (state_q == ACCESS && !r_we) r_word <= reg_rd;
        end
    end

    // Register/input read mux; anything that is neither an output reg nor
    // an input port was either RAM or faulted, so zero is harmless.
    always_comb begin
        reg_rd = '0;
        if (r_out) begin
            for (int k = 0; k < N_OUT; k++)
                if (r_idx == IDX_W'(k)) reg_rd = out_q[k];
        end else begin
            for (int k = 0; k < N_IN; k++)
                if (r_idx == IDX_W'(k)) reg_rd = sync_q[SYNC_STAGES-1][32*k +: 32];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int k = 0; k < N_OUT; k++) out_q[k] <= '0;
        end else if (out_wr) begin
            for (int k = 0; k < N_OUT; k++)
                if (r_idx == IDX_W'(k))
                    for (int b = 0; b < 4; b++)
                        if (be[b]) out_q[k][8*b +: 8] <= wlanes[8*b +: 8];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= i_in_ports;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    always_comb begin
        o_out_regs = '0;
        for (int k = 0; k < N_OUT; k++) o_out_regs[32*k +: 32] = out_q[k];
    end

    lsu_mmio_ram #(
        .MEM_DEPTH_W (MEM_DEPTH_W),
        .ADDR_W      (ADDR_W)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (ram_we),
        .i_re    (ram_re),
        .i_addr  (r_addr[ADDR_W+1:2]),
        .i_wdata (wlanes),
        .o_rdata (ram_q)
    );

endmodule

// File: tb/tb_lsu_mmio_pipe.sv
module tb_lsu_mmio_pipe;

    localparam int N_OUT = 5;
    localparam int N_IN  = 2;
    localparam int SYNC  = 2;

    logic                i_clk = 1'b0;
    logic                i_reset;
    logic                i_req_valid;
    logic                o_req_ready;
    logic                i_req_we;
    logic [31:0]         i_req_addr;
    logic [1:0]          i_req_size;
    logic                i_req_unsigned;
    logic [31:0]         i_req_wdata;
    logic                o_rsp_valid;
    logic                i_rsp_ready;
    logic [31:0]         o_rsp_rdata;
    logic [1:0]          o_rsp_err;
    logic [32*N_OUT-1:0] o_out_regs;
    logic [32*N_IN-1:0]  i_in_ports;

    int total = 0;
    int bad   = 0;

    always #5 i_clk = ~i_clk;

    lsu_mmio_pipe #(
        .MEM_DEPTH_W (4096),
        .N_OUT       (N_OUT),
        .N_IN        (N_IN),
        .SYNC_STAGES (SYNC)
    ) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_req_valid    (i_req_valid),
        .o_req_ready    (o_req_ready),
        .i_req_we       (i_req_we),
        .i_req_addr     (i_req_addr),
        .i_req_size     (i_req_size),
        .i_req_unsigned (i_req_unsigned),
        .i_req_wdata    (i_req_wdata),
        .o_rsp_valid    (o_rsp_valid),
        .i_rsp_ready    (i_rsp_ready),
        .o_rsp_rdata    (o_rsp_rdata),
        .o_rsp_err      (o_rsp_err),
        .o_out_regs     (o_out_regs),
        .i_in_ports     (i_in_ports)
    );

    // One full transaction with i_rsp_ready high; lat counts cycles from the
    // accepting edge to the first cycle with rsp_valid (0 means it never came).
    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [1:0] size,
                          input logic uns, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic [1:0] err, output int lat);
        @(negedge i_clk);
        i_req_valid    = 1'b1;
        i_req_we       = we;
        i_req_addr     = addr;
        i_req_size     = size;
        i_req_unsigned = uns;
        i_req_wdata    = wdata;
        i_rsp_ready    = 1'b1;
        @(posedge i_clk);
        #1 i_req_valid = 1'b0;
        lat   = 0;
        rdata = '0;
        err   = '0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge i_clk);
            if (o_rsp_valid) begin
                lat   = i;
                rdata = o_rsp_rdata;
                err   = o_rsp_err;
                break;
            end
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        repeat (3) @(posedge i_clk);
        #1 i_reset = 1'b0;
        @(negedge i_clk);
        total++;
        if (o_req_ready !== 1'b1 || o_rsp_valid !== 1'b0 || o_rsp_rdata !== 32'h0 || o_rsp_err !== 2'b00) begin
            bad++;
            $display("FAIL reset_outputs: ready=%b valid=%b rdata=%h err=%b, want 1 0 00000000 00",
                     o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err);
        end
        total++;
        if (o_out_regs !== '0) begin
            bad++;
            $display("FAIL reset_out_regs: got %h want 0", o_out_regs);
        end
    endtask

    task automatic test_ram();
        logic [31:0] rd;
        logic [1:0]  er;
        int          lat;
        do_txn(1'b1, 32'h10, 2'b10, 1'b0, 32'h8765_4321, rd, er, lat);
        total++;
        if (lat !== 2 || er !== 2'b00 || rd !== 32'h0) begin
            bad++;
            $display("FAIL ram_store_w: lat=%0d err=%b rdata=%h, want 2 00 00000000", lat, er, rd);
        end
        do_txn(1'b0, 32'h11, 2'b00, 1'b0, 32'h0, rd, er, lat);
        total++;
        if (lat !== 2 || er !== 2'b00 || rd !== 32'h0000_0043) begin
            bad++;
            $display("FAIL ram_load_b_s: lat=%0d err=%b rdata=%h, want 2 00 00000043", lat, er, rd);
        end
        do_txn(1'b0, 32'h12, 2'b01, 1'b0, 32'h0, rd, er, lat);
        total++;
        if (lat !== 2 || er !== 2'b00 || rd !== 32'hFFFF_8765) begin
            bad++;
            $display("FAIL ram_load_h_s: lat=%0d err=%b rdata=%h, want 2 00 ffff8765", lat, er, rd);
        end
        do_txn(1'b0, 32'h12, 2'b01, 1'b1, 32'h0, rd, er, lat);
        total++;
        if (lat !== 2 || er !== 2'b00 || rd !== 32'h0000_8765) begin
            bad++;
            $display("FAIL ram_load_h_u: lat=%0d err=%b rdata=%h, want 2 00 00008765", lat, er, rd);
        end
        do_txn(1'b0, 32'h13, 2'b00, 1'b0, 32'h0, rd, er, lat);
        total++;
        if (rd !== 32'hFFFF_FF87) begin
            bad++;
            $display("FAIL ram_load_b3_s: rdata=%h want ffffff87", rd);
        end
        do_txn(1'b0, 32'h13, 2'b00, 1'b1, 32'h0, rd, er, lat);
        total++;
        if (rd !== 32'h0000_0087) begin
            bad++;
            $display("FAIL ram_load_b3_u: rdata=%h want 00000087", rd);
        end
        do_txn(1'b0, 32'h10, 2'b10, 1'b1, 32'h0, rd, er, lat);
        total++;
        if (rd !== 32'h8765_4321) begin
            bad++;
            $display("FAIL ram_load_w: rdata=%h want 87654321", rd);
        end
    endtask

    task automatic test_out_reg();
        logic [31:0] rd;
        logic [1:0]  er;
        int          lat;
        do_txn(1'b1, 32'h1000_0002, 2'b00, 1'b0, 32'h0000_00AB, rd, er, lat);
        total++;
        if (o_out_regs !== 160'h00AB_0000 || er !== 2'b00) begin
            bad++;
            $display("FAIL out_store_b: regs=%h err=%b, want reg0=00ab0000 others 0, err 00", o_out_regs, er);
        end
        do_txn(1'b0, 32'h1000_0000, 2'b10, 1'b0, 32'h0, rd, er, lat);
        total++;
        if (lat !== 2 || er !== 2'b00 || rd !== 32'h00AB_0000) begin
            bad++;
            $display("FAIL out_load_w: lat=%0d err=%b rdata=%h, want 2 00 00ab0000", lat, er, rd);
        end
        do_txn(1'b1, 32'h1000_4FFE, 2'b01, 1'b0, 32'h1234_BEEF, rd, er, lat);
        total++;
        if (o_out_regs[159:128] !== 32'hBEEF_0000 || o_out_regs[127:0] !== 128'h00AB_0000) begin
            bad++;
            $display("FAIL out_store_h_r4: regs=%h want reg4=beef0000 reg0=00ab0000", o_out_regs);
        end
    endtask

    task automatic test_in_port();
        logic [31:0] rd;
        logic [1:0]  er;
        int          lat;
        @(negedge i_clk);
        i_in_ports = {32'h8000_1234, 32'h0000_00F0};
        repeat (SYNC) @(posedge i_clk);
        #1;
        do_txn(1'b0, 32'h1001_0000, 2'b10, 1'b0, 32'h0, rd, er, lat);
        total++;
        if (lat !== 2 || er !== 2'b00 || rd !== 32'h0000_00F0) begin
            bad++;
            $display("FAIL in0_load_w: lat=%0d err=%b rdata=%h, want 2 00 000000f0", lat, er, rd);
        end
        do_txn(1'b0, 32'h1001_1002, 2'b01, 1'b0, 32'h0, rd, er, lat);
        total++;
        if (er !== 2'b00 || rd !== 32'hFFFF_8000) begin
            bad++;
            $display("FAIL in1_load_h_s: err=%b rdata=%h, want 00 ffff8000", er, rd);
        end
        do_txn(1'b1, 32'h1001_0000, 2'b10, 1'b0, 32'hFFFF_FFFF, rd, er, lat);
        total++;
        if (lat !== 1 || er !== 2'b10 || rd !== 32'h0) begin
            bad++;
            $display("FAIL in_store_fault: lat=%0d err=%b rdata=%h, want 1 10 00000000", lat, er, rd);
        end
        total++;
        if (o_out_regs !== 160'hBEEF_0000_0000_0000_0000_0000_0000_0000_00AB_0000) begin
            bad++;
            $display("FAIL in_store_no_effect: regs=%h", o_out_regs);
        end
    endtask

    task automatic test_faults();
        logic [31:0] rd;
        logic [1:0]  er;
        int          lat;
        do_txn(1'b1, 32'h0, 2'b10, 1'b0, 32'hCAFE_F00D, rd, er, lat);
        do_txn(1'b0, 32'h6, 2'b10, 1'b0, 32'h0, rd, er, lat);
        total++;
        if (lat !== 1 || er !== 2'b01 || rd !== 32'h0) begin
            bad++;
            $display("FAIL misalign_w: lat=%0d err=%b rdata=%h, want 1 01 00000000", lat, er, rd);
        end
        do_txn(1'b1, 32'h2000_0001, 2'b01, 1'b0, 32'h0000_5555, rd, er, lat);
        total++;
        if (lat !== 1 || er !== 2'b11) begin
            bad++;
            $display("FAIL both_faults: lat=%0d err=%b, want 1 11", lat, er);
        end
        do_txn(1'b1, 32'h1, 2'b01, 1'b0, 32'h0000_5555, rd, er, lat);
        total++;
        if (er !== 2'b01) begin
            bad++;
            $display("FAIL misalign_h_store: err=%b want 01", er);
        end
        do_txn(1'b1, 32'h0, 2'b11, 1'b0, 32'h0000_5555, rd, er, lat);
        total++;
        if (er !== 2'b01) begin
            bad++;
            $display("FAIL size11: err=%b want 01", er);
        end
        do_txn(1'b0, 32'h0, 2'b10, 1'b0, 32'h0, rd, er, lat);
        total++;
        if (er !== 2'b00 || rd !== 32'hCAFE_F00D) begin
            bad++;
            $display("FAIL ram_untouched: err=%b rdata=%h, want 00 cafef00d", er, rd);
        end
        do_txn(1'b0, 32'h0000_4000, 2'b10, 1'b0, 32'h0, rd, er, lat);
        total++;
        if (lat !== 1 || er !== 2'b10) begin
            bad++;
            $display("FAIL ram_end_unmapped: lat=%0d err=%b, want 1 10", lat, er);
        end
        do_txn(1'b0, 32'h1000_5000, 2'b10, 1'b0, 32'h0, rd, er, lat);
        total++;
        if (er !== 2'b10) begin
            bad++;
            $display("FAIL out_past_last: err=%b want 10", er);
        end
    endtask

    task automatic test_backpressure();
        int got;
        @(negedge i_clk);
        i_req_valid    = 1'b1;
        i_req_we       = 1'b0;
        i_req_addr     = 32'h10;
        i_req_size     = 2'b10;
        i_req_unsigned = 1'b0;
        i_rsp_ready    = 1'b0;
        @(posedge i_clk);
        #1 i_req_valid = 1'b0;
        got = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge i_clk);
            if (o_rsp_valid) begin
                got = 1;
                break;
            end
        end
        total++;
        if (got != 1) begin
            bad++;
            $display("FAIL bp_rsp_arrives: rsp_valid never rose within 10 cycles");
        end
        i_req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge i_clk);
            total++;
            if (o_rsp_valid !== 1'b1 || o_rsp_rdata !== 32'h8765_4321 || o_rsp_err !== 2'b00 || o_req_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold_%0d: valid=%b rdata=%h err=%b ready=%b, want 1 87654321 00 0",
                         i, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_req_ready);
            end
        end
        i_req_valid = 1'b0;
        i_rsp_ready = 1'b1;
        @(negedge i_clk);
        total++;
        if (o_req_ready !== 1'b1 || o_rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_release: ready=%b valid=%b, want 1 0", o_req_ready, o_rsp_valid);
        end
    endtask

    task automatic test_back_to_back();
        int acc;
        int rsp;
        @(negedge i_clk);
        i_req_valid    = 1'b1;
        i_req_we       = 1'b0;
        i_req_addr     = 32'h10;
        i_req_size     = 2'b10;
        i_req_unsigned = 1'b0;
        i_rsp_ready    = 1'b1;
        acc = 0;
        rsp = 0;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge i_clk);
            if (o_req_ready) acc++;
            if (o_rsp_valid) rsp++;
        end
        @(posedge i_clk);
        #1 i_req_valid = 1'b0;
        total++;
        if (acc != 3 || rsp != 3) begin
            bad++;
            $display("FAIL back_to_back: accepts=%0d responses=%0d in 9 cycles, want 3 3", acc, rsp);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic [1:0]  er;
        int          lat;
        do_txn(1'b1, 32'h20, 2'b10, 1'b0, 32'h0BAD_BEEF, rd, er, lat);
        do_txn(1'b1, 32'h1000_1000, 2'b10, 1'b0, 32'h5A5A_5A5A, rd, er, lat);
        @(negedge i_clk);
        i_req_valid = 1'b1;
        i_req_we    = 1'b1;
        i_req_addr  = 32'h20;
        i_req_size  = 2'b10;
        i_req_wdata = 32'h1234_5678;
        @(posedge i_clk);
        #1;
        i_req_valid = 1'b0;
        i_reset     = 1'b1;
        @(posedge i_clk);
        #1 i_reset = 1'b0;
        @(negedge i_clk);
        total++;
        if (o_req_ready !== 1'b1 || o_rsp_valid !== 1'b0 || o_out_regs !== '0) begin
            bad++;
            $display("FAIL reset_mid_state: ready=%b valid=%b regs=%h, want 1 0 0", o_req_ready, o_rsp_valid, o_out_regs);
        end
        do_txn(1'b0, 32'h20, 2'b10, 1'b0, 32'h0, rd, er, lat);
        total++;
        if (lat !== 2 || er !== 2'b00 || rd !== 32'h0BAD_BEEF) begin
            bad++;
            $display("FAIL reset_mid_dropped: lat=%0d err=%b rdata=%h, want 2 00 0badbeef", lat, er, rd);
        end
    endtask

    initial begin
        i_reset        = 1'b1;
        i_req_valid    = 1'b0;
        i_req_we       = 1'b0;
        i_req_addr     = '0;
        i_req_size     = '0;
        i_req_unsigned = 1'b0;
        i_req_wdata    = '0;
        i_rsp_ready    = 1'b1;
        i_in_ports     = '0;
        test_reset();
        test_ram();
        test_out_reg();
        test_in_port();
        test_faults();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
